// File: rtl/pps_pkg.sv
// Shared constants for the instruction fetch front end.
package pps_pkg;

    localparam int unsigned PC_W_DEF     = 32;
    localparam int unsigned INST_W       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0;
    localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/pps_sync_fifo.sv
// Synchronous FIFO with flush, count output and a head read straight from storage.
module pps_sync_fifo #(
    parameter int unsigned      WIDTH     = 64,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         valid,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full queue is only legal when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem    <= '{default: RESET_VAL};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign dout  = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/pps_fetch_q.sv
// Credit-based instruction fetcher: issues sequential fetches, tracks in-flight
// responses, drops stale ones after a redirect and queues the rest for decode.
module pps_fetch_q
    import pps_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              id_valid,
    output logic [INST_W-1:0] id_inst,
    output logic [PC_W-1:0]   id_pc,
    input  logic              id_ready
);

    localparam int unsigned     CNT_W       = $clog2(DEPTH) + 1;
    localparam int unsigned     ENTRY_W     = PC_W + INST_W;
    localparam logic [PC_W-1:0] ALIGN_MASK  = ~PC_W'(PC_INC - 1);
    localparam logic [PC_W-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;
    localparam logic [ENTRY_W-1:0] ENTRY_RESET = {RESET_PC_AL, INST_W'(0)};

    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    resp_pc;
    logic [PC_W-1:0]    target_pc;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   outstanding_next;
    logic [CNT_W-1:0]   discard;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     credit_used;
    logic               issue;
    logic               accept;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // Credits cover both in-flight fetches and queued entries so the queue cannot overflow.
    always_comb begin
        credit_used      = {1'b0, outstanding} + {1'b0, fifo_count};
        imem_req         = rst_n && !redirect && (credit_used < (CNT_W + 1)'(DEPTH));
        issue            = imem_req && imem_gnt;
        target_pc        = redirect_pc & ALIGN_MASK;
        outstanding_next = outstanding;
        if (issue && !imem_rvalid) begin
            outstanding_next = outstanding + CNT_W'(1);
        end else if (!issue && imem_rvalid && (outstanding != '0)) begin
            outstanding_next = outstanding - CNT_W'(1);
        end
        accept = imem_rvalid && !redirect && (discard == '0);
        pop    = id_valid && id_ready;
    end

    // A redirect marks every fetch still in flight after this cycle as stale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC_AL;
            resp_pc     <= RESET_PC_AL;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect) begin
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                discard  <= outstanding_next;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + PC_W'(PC_INC);
                end
                if (accept) begin
                    resp_pc <= resp_pc + PC_W'(PC_INC);
                end
                if (imem_rvalid && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
            end
        end
    end

    assign imem_addr = fetch_pc;

    pps_sync_fifo #(
        .WIDTH     (ENTRY_W),
        .DEPTH     (DEPTH),
        .RESET_VAL (ENTRY_RESET)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (accept),
        .din   ({resp_pc, imem_rdata}),
        .pop   (pop),
        .dout  (head),
        .valid (id_valid),
        .count (fifo_count)
    );

    assign id_pc   = head[ENTRY_W-1:INST_W];
    assign id_inst = head[INST_W-1:0];

    // Protocol sanity: bounded credits and no response without a fetch in flight.
    a_out_range: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding <= CNT_W'(DEPTH));
    a_rvalid_owed: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (outstanding != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (accept && !pop) |-> (fifo_count < CNT_W'(DEPTH)));

endmodule

// File: tb/tb_pps_fetch_q.sv
// Directed bench for pps_fetch_q: a cycle table plus a streaming sequence with an in-order memory.
module tb_pps_fetch_q;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;

    pps_fetch_q #(.PC_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_ready    (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        red;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic        chk;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] pend[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          issues      = 0;
    int          delivered   = 0;
    logic [31:0] exp_pc      = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic add(input logic rst, input logic red, input logic [31:0] rpc,
                       input logic gnt, input logic rv, input logic [31:0] rd, input logic rdy,
                       input logic e_req, input logic [31:0] e_addr, input logic e_val,
                       input logic chk, input logic [31:0] e_pc, input logic [31:0] e_inst);
        vec_t v;
        v = '{rst, red, rpc, gnt, rv, rd, rdy, e_req, e_addr, e_val, chk, e_pc, e_inst};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One cycle against the in-order, 1-cycle-latency memory model.
    task automatic mcycle(input logic g, input logic r, output logic req_o);
        @(negedge clk);
        rst_n    = 1'b1;
        redirect = 1'b0;
        imem_gnt = g;
        id_ready = r;
        if (pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        req_o = imem_req;
        if (imem_req && imem_gnt) begin
            pend.push_back(imem_addr);
            issues++;
        end
        if (id_valid && id_ready) begin
            check("stream_pc", id_pc, exp_pc);
            check("stream_inst", id_inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
    endtask

    initial begin
        logic req_s;
        bit   ok;

        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b0;

        //   rst red rpc           gnt rv rd            rdy | req addr          val chk pc            inst
        add(0, 0, 32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0, 1, 32'h0,         32'h0);
        add(1, 0, 32'h0,         1, 0, 32'h0,         1,  1, 32'h0,         0, 1, 32'h0,         32'h0);
        add(1, 0, 32'h0,         1, 1, 32'hC0DE0000,  1,  1, 32'h4,         0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         1, 1, 32'hC0DE0004,  1,  1, 32'h8,         1, 1, 32'h0,         32'hC0DE0000);
        add(1, 0, 32'h0,         1, 1, 32'hC0DE0008,  1,  1, 32'hC,         1, 1, 32'h4,         32'hC0DE0004);
        add(1, 0, 32'h0,         1, 1, 32'hC0DE000C,  0,  1, 32'h10,        1, 1, 32'h8,         32'hC0DE0008);
        add(1, 0, 32'h0,         1, 1, 32'hC0DE0010,  0,  1, 32'h14,        1, 1, 32'h8,         32'hC0DE0008);
        add(1, 0, 32'h0,         1, 1, 32'hC0DE0014,  0,  0, 32'h18,        1, 1, 32'h8,         32'hC0DE0008);
        add(1, 0, 32'h0,         1, 0, 32'h0,         0,  0, 32'h18,        1, 1, 32'h8,         32'hC0DE0008);
        add(1, 0, 32'h0,         1, 0, 32'h0,         1,  0, 32'h18,        1, 1, 32'h8,         32'hC0DE0008);
        add(1, 0, 32'h0,         1, 0, 32'h0,         1,  1, 32'h18,        1, 1, 32'hC,         32'hC0DE000C);
        add(1, 0, 32'h0,         1, 0, 32'h0,         1,  1, 32'h1C,        1, 1, 32'h10,        32'hC0DE0010);
        add(1, 0, 32'h0,         1, 0, 32'h0,         1,  1, 32'h20,        1, 1, 32'h14,        32'hC0DE0014);
        // redirect with three in flight, unaligned target
        add(1, 1, 32'h103,       1, 0, 32'h0,         1,  0, 32'h24,        0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 1, 32'hDEAD0018,  1,  1, 32'h100,       0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         1, 1, 32'hDEAD001C,  1,  1, 32'h100,       0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         1, 1, 32'hDEAD0020,  1,  1, 32'h104,       0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 1, 32'hC0DE0100,  1,  1, 32'h108,       0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 1, 32'hC0DE0104,  1,  1, 32'h108,       1, 1, 32'h100,       32'hC0DE0100);
        add(1, 0, 32'h0,         0, 0, 32'h0,         1,  1, 32'h108,       1, 1, 32'h104,       32'hC0DE0104);
        add(1, 0, 32'h0,         0, 0, 32'h0,         1,  1, 32'h108,       0, 0, 32'h0,         32'h0);
        // redirect coinciding with a response, two in flight
        add(1, 0, 32'h0,         1, 0, 32'h0,         1,  1, 32'h108,       0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         1, 0, 32'h0,         1,  1, 32'h10C,       0, 0, 32'h0,         32'h0);
        add(1, 1, 32'h200,       1, 1, 32'hBAD00108,  1,  0, 32'h110,       0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 1, 32'hBAD0010C,  1,  1, 32'h200,       0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         1, 0, 32'h0,         1,  1, 32'h200,       0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 1, 32'hC0DE0200,  1,  1, 32'h204,       0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 0, 32'h0,         1,  1, 32'h204,       1, 1, 32'h200,       32'hC0DE0200);
        // PC wrap
        add(1, 1, 32'hFFFFFFFC,  1, 0, 32'h0,         1,  0, 32'h204,       0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         1, 0, 32'h0,         1,  1, 32'hFFFFFFFC,  0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         1, 1, 32'hC0DEFFFC,  1,  1, 32'h0,         0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 1, 32'hDA7A0000,  1,  1, 32'h4,         1, 1, 32'hFFFFFFFC,  32'hC0DEFFFC);
        add(1, 0, 32'h0,         0, 0, 32'h0,         1,  1, 32'h4,         1, 1, 32'h0,         32'hDA7A0000);
        // two redirects one cycle apart
        add(1, 0, 32'h0,         1, 0, 32'h0,         1,  1, 32'h4,         0, 0, 32'h0,         32'h0);
        add(1, 1, 32'h300,       1, 0, 32'h0,         1,  0, 32'h8,         0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         1, 0, 32'h0,         1,  1, 32'h300,       0, 0, 32'h0,         32'h0);
        add(1, 1, 32'h400,       1, 1, 32'hBAD00004,  1,  0, 32'h304,       0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         1, 1, 32'hBAD00300,  1,  1, 32'h400,       0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 1, 32'hC0DE0400,  1,  1, 32'h404,       0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 0, 32'h0,         1,  1, 32'h404,       1, 1, 32'h400,       32'hC0DE0400);
        // reset mid-stream
        add(1, 0, 32'h0,         1, 0, 32'h0,         0,  1, 32'h404,       0, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         1, 1, 32'hC0DE0404,  0,  1, 32'h408,       0, 0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         1, 1, 32'hC0DE0408,  0,  0, 32'h40C,       1, 1, 32'h404,       32'hC0DE0404);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0, 1, 32'h0,         32'h0);

        // one reset edge before the table so state is defined
        @(negedge clk);
        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            rst_n       = vecs[i].rst;
            redirect    = vecs[i].red;
            redirect_pc = vecs[i].rpc;
            imem_gnt    = vecs[i].gnt;
            imem_rvalid = vecs[i].rv;
            imem_rdata  = vecs[i].rd;
            id_ready    = vecs[i].rdy;
            #1;
            ok = (imem_req === vecs[i].e_req) && (imem_addr === vecs[i].e_addr) &&
                 (id_valid === vecs[i].e_val) &&
                 (!vecs[i].chk || ((id_pc === vecs[i].e_pc) && (id_inst === vecs[i].e_inst)));
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL row%0d: req=%b addr=%h val=%b pc=%h inst=%h, required req=%b addr=%h val=%b pc=%h inst=%h",
                         i, imem_req, imem_addr, id_valid, id_pc, id_inst,
                         vecs[i].e_req, vecs[i].e_addr, vecs[i].e_val, vecs[i].e_pc, vecs[i].e_inst);
            end
        end

        // Credit limit from reset: decode stalled, exactly DEPTH issues.
        issues = 0;
        for (int c = 0; c < 8; c++) begin
            mcycle(1'b1, 1'b0, req_s);
        end
        check("stall_issues", 32'(issues), 32'd4);
        check("stall_req", {31'h0, req_s}, 32'h0);
        check("stall_valid", {31'h0, id_valid}, 32'h1);
        check("stall_head_pc", id_pc, 32'h0);
        check("stall_head_inst", id_inst, mem_word(32'h0));

        mcycle(1'b1, 1'b1, req_s);
        check("resume_req_same", {31'h0, req_s}, 32'h0);
        mcycle(1'b1, 1'b1, req_s);
        check("resume_req_next", {31'h0, req_s}, 32'h1);

        // Streaming with irregular grant and back-pressure.
        for (int c = 0; c < 30; c++) begin
            mcycle(1'b1 ^ ((c % 3) == 2), 1'b1 ^ ((c % 4) == 3), req_s);
        end
        vectors++;
        if (delivered < 12) begin
            miscompares++;
            $display("FAIL stream_progress: got %0d deliveries, required at least 12", delivered);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
